sdram_port_arbiter: RTL

Arbitrates the internal SDRAM-side interfaces of NR_PORTS wishbone port blocks onto the single request interface of the SDRAM controller.
- Arbitration is round-robin.
- The grant is held across the two-burst read sequence each port issues.
- Read data and acks are routed back to the granted port.
- Each completed 32-bit port write is broadcast on the buffer-write bus so every other port keeps its read buffer coherent.
- Sits between the port blocks and the SDRAM controller, entirely in the SDRAM clock domain.

---
 rtl/sdram_port_arbiter_if.sv | 36 +++
 rtl/sdram_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Port-block / SDRAM-controller signal bundle around the arbiter.
// Member suffixes (_i/_o) are named from the arbiter's side.
interface sdram_port_arbiter_if #(
  parameter int NR_PORTS = 2
);
  logic [32*NR_PORTS-1:0] adr_i;
  logic [16*NR_PORTS-1:0] dat_i;
  logic [2*NR_PORTS-1:0]  sel_i;
  logic [NR_PORTS-1:0]    acc_i;
  logic [NR_PORTS-1:0]    we_i;
  logic [NR_PORTS-1:0]    ack_o;
  logic [15:0]            dat_o;
  logic [31:0]            adr_o;
  logic [15:0]            sdr_dat_o;
  logic [1:0]             sel_o;
  logic                   acc_o;
  logic                   we_o;
  logic                   ack_i;
  logic [15:0]            sdr_dat_i;
  logic [31:0]            bufw_adr_o;
  logic [31:0]            bufw_dat_o;
  logic [3:0]             bufw_sel_o;
  logic [NR_PORTS-1:0]    bufw_we_o;

  modport slave (
    input  adr_i, dat_i, sel_i, acc_i, we_i, ack_i, sdr_dat_i,
    output ack_o, dat_o, adr_o, sdr_dat_o, sel_o, acc_o, we_o,
           bufw_adr_o, bufw_dat_o, bufw_sel_o, bufw_we_o
  );

  modport master (
    output adr_i, dat_i, sel_i, acc_i, we_i, ack_i, sdr_dat_i,
    input  ack_o, dat_o, adr_o, sdr_dat_o, sel_o, acc_o, we_o,
           bufw_adr_o, bufw_dat_o, bufw_sel_o, bufw_we_o
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter of NR_PORTS port blocks onto one SDRAM controller port,
// holding the grant across read bursts and broadcasting writes for buffer snooping.
module sdram_port_arbiter #(
  parameter int NR_PORTS    = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int OW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [OW-1:0] LAST_INIT = OW'(NR_PORTS - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD, SNOOP} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, last_q, last_d, pick;
  logic [HW-1:0] hold_q, hold_d;
  logic          first_q, first_d, found;
  logic [31:0]   badr_q, badr_d, bdat_q, bdat_d;
  logic [3:0]    bsel_q, bsel_d;

  logic [31:0]         own_adr;
  logic [15:0]         own_dat;
  logic [1:0]          own_sel;
  logic                own_acc, own_we;
  logic [NR_PORTS-1:0] owner_mask;

  assign own_adr    = bus.adr_i[32*int'(owner_q) +: 32];
  assign own_dat    = bus.dat_i[16*int'(owner_q) +: 16];
  assign own_sel    = bus.sel_i[2*int'(owner_q) +: 2];
  assign own_acc    = bus.acc_i[owner_q];
  assign own_we     = bus.we_i[owner_q];
  assign owner_mask = NR_PORTS'(1) << owner_q;

  // First requester searching upward from the port after the last one served
  always_comb begin
    int            idx;
    logic [OW-1:0] cand;
    idx   = 0;
    cand  = '0;
    pick  = owner_q;
    found = 1'b0;
    for (int i = 1; i <= NR_PORTS; i++) begin
      idx  = (int'(last_q) + i) % NR_PORTS;
      cand = OW'(idx);
      if (!found && bus.acc_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_INIT;
      hold_q  <= '0;
      first_q <= 1'b0;
      badr_q  <= '0;
      bdat_q  <= '0;
      bsel_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      first_q <= first_d;
      badr_q  <= badr_d;
      bdat_q  <= bdat_d;
      bsel_q  <= bsel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    first_d = 1'b0;
    badr_d  = badr_q;
    bdat_d  = bdat_q;
    bsel_d  = bsel_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d = pick;
        first_d = 1'b1;
        state_d = GRANT;
      end
      GRANT: begin
        if (own_we) begin
          // Port presents the upper half first, the lower half on the ack cycle
          if (first_q) begin
            badr_d         = {own_adr[31:2], 2'b00};
            bdat_d[31:16]  = own_dat;
            bsel_d[3:2]    = own_sel;
          end
          if (bus.ack_i) begin
            bdat_d[15:0] = own_dat;
            bsel_d[1:0]  = own_sel;
            last_d       = owner_q;
            state_d      = SNOOP;
          end
        end else if (!own_acc) begin
          hold_d  = HOLD_INIT;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (own_acc) begin
          first_d = 1'b1;
          state_d = GRANT;
        end else if (hold_q == '0) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      SNOOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.adr_o     = '0;
    bus.sdr_dat_o = '0;
    bus.sel_o     = '0;
    bus.we_o      = 1'b0;
    bus.acc_o     = 1'b0;
    bus.ack_o     = '0;
    bus.bufw_we_o = '0;
    bus.dat_o     = bus.sdr_dat_i;
    if (state_q == GRANT || state_q == HOLD) begin
      bus.adr_o          = own_adr;
      bus.sdr_dat_o      = own_dat;
      bus.sel_o          = own_sel;
      bus.we_o           = own_we;
      bus.acc_o          = own_acc;
      bus.ack_o[owner_q] = bus.ack_i;
    end
    if (state_q == SNOOP)
      bus.bufw_we_o = ~owner_mask;
  end

  assign bus.bufw_adr_o = badr_q;
  assign bus.bufw_dat_o = bdat_q;
  assign bus.bufw_sel_o = bsel_q;
endmodule
